fetch_stall_ctrl: RTL

Front-end pipeline control for the five-stage MIPS CPU. It owns the PC register, the IF/ID pipeline register and the control half of the ID/EX register. It acts on the hazard unit's PCWrite / IF_ID_Write / Stall outputs by holding the PC, freezing IF/ID and inserting ID/EX bubbles. It also applies taken-branch redirects with an IF/ID flush, detects a halt instruction and drains the pipeline, and keeps stall and flush performance counters.

---
 rtl/fetch_stall_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_stall_ctrl.sv
// Front-end pipeline control: PC register, IF/ID register and ID/EX control half.
// Applies hazard-unit stalls, taken-branch flushes, halt drain and perf counters.
module fetch_stall_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned CTRL_W       = 16,
  parameter logic [31:0] DRAIN_CYCLES = 32'd4,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              IF_ID_Write,
  input  logic              Stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       imem_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc4,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              id_ex_bubble,
  output logic              halted,
  output logic [31:0]       stall_count,
  output logic [15:0]       flush_count
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t            state, state_n;
  logic [31:0]       drain_cnt, drain_cnt_n;
  logic [31:0]       pc_n, if_id_instr_n, if_id_pc4_n;
  logic [CTRL_W-1:0] id_ex_ctrl_n;
  logic              id_ex_bubble_n;
  logic [31:0]       stall_count_n;
  logic [15:0]       flush_count_n;
  logic [31:0]       pc_plus4;
  logic              halt_hit;

  assign pc_plus4 = pc + 32'd4;
  assign halt_hit = (imem_instr == HALT_WORD);
  // halted decodes the state register directly, so it stays input-independent
  assign halted   = (state == HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      drain_cnt    <= '0;
      pc           <= RESET_PC;
      if_id_instr  <= '0;
      if_id_pc4    <= '0;
      id_ex_ctrl   <= '0;
      id_ex_bubble <= 1'b0;
      stall_count  <= '0;
      flush_count  <= '0;
    end else begin
      state        <= state_n;
      drain_cnt    <= drain_cnt_n;
      pc           <= pc_n;
      if_id_instr  <= if_id_instr_n;
      if_id_pc4    <= if_id_pc4_n;
      id_ex_ctrl   <= id_ex_ctrl_n;
      id_ex_bubble <= id_ex_bubble_n;
      stall_count  <= stall_count_n;
      flush_count  <= flush_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    drain_cnt_n   = drain_cnt;
    pc_n          = pc;
    if_id_instr_n = if_id_instr;
    if_id_pc4_n   = if_id_pc4;
    stall_count_n = stall_count;
    flush_count_n = flush_count;

    if (Stall) begin
      id_ex_ctrl_n   = '0;
      id_ex_bubble_n = 1'b1;
    end else begin
      id_ex_ctrl_n   = id_ctrl;
      id_ex_bubble_n = 1'b0;
    end

    case (state)
      RUN: begin
        // Branch outranks halt: a halt word behind a taken branch is wrong-path
        if (!PCWrite) begin
          pc_n = pc;
        end else if (branch_taken) begin
          pc_n = branch_target;
        end else if (halt_hit) begin
          state_n     = DRAIN;
          drain_cnt_n = DRAIN_CYCLES;
        end else begin
          pc_n = pc_plus4;
        end

        if (!IF_ID_Write) begin
          if_id_instr_n = if_id_instr;
        end else if (PCWrite && (branch_taken || halt_hit)) begin
          if_id_instr_n = '0;
          if_id_pc4_n   = '0;
        end else begin
          if_id_instr_n = imem_instr;
          if_id_pc4_n   = pc_plus4;
        end

        if (!PCWrite && (stall_count != '1))
          stall_count_n = stall_count + 32'd1;
        if (PCWrite && branch_taken && (flush_count != '1))
          flush_count_n = flush_count + 16'd1;
      end
      DRAIN: begin
        if_id_instr_n = '0;
        if_id_pc4_n   = '0;
        drain_cnt_n   = drain_cnt - 32'd1;
        if (drain_cnt == 32'd1)
          state_n = HALTED;
      end
      HALTED: begin
        state_n = HALTED;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

endmodule
